// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: two half adders form a full adder around a carry
// flop, processing the loaded operands LSB-first, one bit per clock.

module half_adder (
   input  logic x,
   input  logic y,
   output logic sum,
   output logic carry
);
   assign sum   = x ^ y;
   assign carry = x & y;
endmodule

module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] a_sr_r, a_sr_s;
   logic [WIDTH-1:0] b_sr_r, b_sr_s;
   logic [WIDTH-1:0] sum_sr_r, sum_sr_s;
   logic             carry_r, carry_s;
   logic [CW-1:0]    count_r, count_s;
   logic [WIDTH-1:0] sum_r, sum_s;
   logic             carry_out_r, carry_out_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;

   logic             h1_sum_s, h1_carry_s;
   logic             h2_sum_s, h2_carry_s;
   logic             bit_carry_s;
   logic [WIDTH-1:0] shifted_sum_s;

   half_adder u_h1 (
      .x     (a_sr_r[0]),
      .y     (b_sr_r[0]),
      .sum   (h1_sum_s),
      .carry (h1_carry_s)
   );

   half_adder u_h2 (
      .x     (h1_sum_s),
      .y     (carry_r),
      .sum   (h2_sum_s),
      .carry (h2_carry_s)
   );

   assign bit_carry_s = h1_carry_s | h2_carry_s;
   // Written as a shift/OR so the expression stays legal for WIDTH=1.
   assign shifted_sum_s = (sum_sr_r >> 1) | (WIDTH'(h2_sum_s) << (WIDTH - 1));

   // Next-state, datapath and output-register decode.
   always_comb begin
      state_s     = state_r;
      a_sr_s      = a_sr_r;
      b_sr_s      = b_sr_r;
      sum_sr_s    = sum_sr_r;
      carry_s     = carry_r;
      count_s     = count_r;
      sum_s       = sum_r;
      carry_out_s = carry_out_r;
      done_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               a_sr_s   = a;
               b_sr_s   = b;
               sum_sr_s = {WIDTH{1'b0}};
               carry_s  = 1'b0;
               count_s  = {CW{1'b0}};
               state_s  = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            a_sr_s   = a_sr_r >> 1;
            b_sr_s   = b_sr_r >> 1;
            sum_sr_s = shifted_sum_s;
            carry_s  = bit_carry_s;
            if (count_r == LAST_BIT) begin
               sum_s       = shifted_sum_s;
               carry_out_s = bit_carry_s;
               done_s      = 1'b1;
               count_s     = {CW{1'b0}};
               state_s     = IDLE;
            end else begin
               count_s = count_r + CW'(1);
               state_s = RUN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s == RUN);
   end

   // State and datapath registers; rst overrides every other update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         a_sr_r      <= {WIDTH{1'b0}};
         b_sr_r      <= {WIDTH{1'b0}};
         sum_sr_r    <= {WIDTH{1'b0}};
         carry_r     <= 1'b0;
         count_r     <= {CW{1'b0}};
         sum_r       <= {WIDTH{1'b0}};
         carry_out_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         a_sr_r      <= a_sr_s;
         b_sr_r      <= b_sr_s;
         sum_sr_r    <= sum_sr_s;
         carry_r     <= carry_s;
         count_r     <= count_s;
         sum_r       <= sum_s;
         carry_out_r <= carry_out_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign sum       = sum_r;
   assign carry_out = carry_out_r;
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder that consumes the sum/carry outputs of two half_adder instances. The two instances are chained into a full adder, and a carry flip-flop sits in the loop. Both operands are loaded in parallel on a start strobe, then added LSB-first at one bit per clock. The block is the sequential stage directly downstream of half_adder, and is the team's first clocked arithmetic block.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an addition; sampled only when busy=0
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse when sum/carry_out take a new result
sum  output  WIDTH  result register; holds last result until the next completion
carry_out  output  1  final carry of last result; holds like sum

Behaviour:
- Reset: rst=1 at a rising edge sets the state to IDLE and clears the internal registers.
  - Cleared outputs: busy=0, done=0, sum=0, carry_out=0.
  - Cleared internals: operand shift registers, carry flop, sum shift register, bit counter.
  - rst has priority over start and over every other action.
- States: IDLE, RUN.
- IDLE:
  - If start=1, the edge loads a into a_sr and b into b_sr, clears the carry flop, sets count=0, and moves to RUN.
  - busy is 1 from the next cycle.
  - If start=0, state is unchanged.
- RUN, each edge:
  - Bit datapath: h1 = half_adder(a_sr[0], b_sr[0]); h2 = half_adder(h1.sum, carry).
  - Result bit: s = h2.sum; the new carry = h1.carry | h2.carry.
  - Shifts: a_sr and b_sr shift right by one. s shifts into the MSB of sum_sr, which shifts right. count increments.
  - When count == WIDTH-1 on this edge:
    - The completed sum_sr value, including the bit just computed, is written to sum.
    - The new carry is written to carry_out.
    - done=1 for the following cycle only, and the state returns to IDLE (busy=0).
- Latency: start is accepted at edge E0, and done/sum/carry_out are valid after edge E0+WIDTH.
  - Throughput is one addition per WIDTH+1 cycles.
  - Back-to-back operation is allowed: start=1 in the cycle where done=1 is accepted, since the state is already IDLE.
- start while busy=1 is ignored: no reload and no restart. a/b changes during RUN have no effect.
- sum and carry_out change only at completion. They stay stable during RUN and during IDLE.
- Arithmetic: {carry_out, sum} = a + b as a (WIDTH+1)-bit unsigned result. Overflow wraps into sum, with carry_out=1.
- WIDTH=1: RUN lasts exactly one edge, so done appears after edge E0+1.
- Reset mid-RUN: the operation is abandoned, and done does not pulse. sum/carry_out clear to 0. The next start after rst falls behaves normally.
- No X on any output after the first reset edge. Outputs before the first reset are undefined.

Test Plan:
- WIDTH=4, rst for 2 cycles -> busy=0, done=0, sum=4'b0000, carry_out=0.
- a=4'd3, b=4'd5, start one cycle -> busy=1 for 4 cycles; done pulses after 4th RUN edge; sum=4'b1000, carry_out=0.
- a=4'd15, b=4'd1, then a=4'd15, b=4'd15 started in the done cycle -> first result sum=4'b0000, carry_out=1. Second result sum=4'b1110, carry_out=1, five cycles after the first done.
- a=4'd6, b=4'd7 accepted; during RUN hold start=1 with a=4'd1, b=4'd1 -> still exactly one done; sum=4'b1101, carry_out=0; no second operation starts until start is seen in IDLE.
- a=4'd9, b=4'd9 accepted; rst asserted after 2 RUN edges -> no done pulse; sum=0, carry_out=0, busy=0. Then a=4'd2, b=4'd2 -> sum=4'b0100, carry_out=0.
- WIDTH=1 build: a=1, b=1, start -> done after one RUN edge, sum=1'b0, carry_out=1. a=1, b=0 -> sum=1'b1, carry_out=0.
